csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
Machine-mode CSR file and trap responder for the XYZ core. Consumes the decoder's CSR, trap and mret requests and executes them: CSR read-modify-write, trap entry, mret return and interrupt arbitration. Drives the redirect flag (PC_csr) and target PC back to the fetch/PC logic. Holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mhartid and the 64-bit cycle/instret counters.

Parameters:
HART_ID, 32'd0, value read from mhartid (0xF14).
RESET_MTVEC, 32'h0000_0000, reset value of mtvec; bits [1:0] give the reset mode.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
valid_i  input  1  instruction in this stage is valid (not a bubble)
stall_i  input  1  pipeline stall; blocks every state commit
is_csr_i  input  1  CSR instruction or mret from the decoder
csr_op_i  input  2  01 write, 10 set, 11 clear, 00 none
csr_addr_i  input  12  CSR address (instr[31:20])
csr_wdata_i  input  32  rs1 value or zero-extended zimm, already muxed
is_trap_i  input  1  decoder exception request
cause_trap_i  input  4  exception code (2 illegal, 3 breakpoint, 11 ecall)
is_mret_i  input  1  mret
pc_i  input  32  PC of the instruction in this stage
tval_i  input  32  value for mtval on an exception
retire_i  input  1  one instruction retires this cycle
ext_irq_i  input  1  external interrupt level (MEIP)
timer_irq_i  input  1  timer interrupt level (MTIP)
csr_rdata_o  output  32  old CSR value, combinational
PC_csr_o  output  1  redirect to trap_pc_o, combinational
trap_pc_o  output  32  redirect target
illegal_csr_o  output  1  unknown address, or write to a read-only CSR

Behaviour:
- Reset values (rst_i=1 at the clock edge):
  - mstatus.MIE=0, mstatus.MPIE=0; MPP reads 2'b11.
  - mie=0; mip.MSIP=0.
  - mtvec=RESET_MTVEC.
  - mscratch, mepc, mcause, mtval = 0; counters = 0.
  - With rst_i high, PC_csr_o=0 and no state commits.
- Commit condition: commit = valid_i & ~stall_i. No register changes without commit, except the counters.
- CSR access (is_csr_i & ~is_mret_i):
  - csr_rdata_o always returns the pre-write value.
  - New value: op 01 gives wdata; 10 gives old|wdata; 11 gives old&~wdata. Written at the edge.
  - Op 10/11 with wdata=0 is a pure read: no write, never illegal on a read-only CSR.
- Legal addresses: 0x300, 0x304, 0x305, 0x340–0x344, 0xB00/0xB80/0xB02/0xB82, 0xC00/0xC80/0xC02/0xC82, 0xF14.
  - 0xCxx and 0xF14 are read-only.
  - mip: only bit 3 (MSIP) is writable; bit 7=timer_irq_i, bit 11=ext_irq_i, live.
  - mepc[1:0] reads 0. mtvec[1] is forced 0.
  - mie: bits 3, 7, 11 implemented; all others read 0.
- Illegal CSR access: illegal_csr_o=1, no write. Treated as an exception with cause 2 and mtval=pc_i... except mtval is instr-less, so mtval=0.
- Exception entry (commit & (is_trap_i | illegal_csr_o)):
  - PC_csr_o=1; trap_pc_o={mtvec[31:2],2'b00}.
  - At the edge: mepc<=pc_i, mcause<={1'b0,27'b0,cause}, mtval<=tval_i, MPIE<=MIE, MIE<=0.
- Interrupt entry (commit & MIE & |(mie&mip) & no exception):
  - Priority: external (11) > software (3) > timer (7).
  - mepc<=pc_i (the instruction is not executed); mcause<={1'b1,27'b0,code}; mtval<=0.
  - trap_pc_o = base + 4*code when mtvec[0]=1, else base.
  - The CSR write of that instruction is suppressed.
- mret (commit & is_mret_i & ~is_trap_i):
  - PC_csr_o=1, trap_pc_o=mepc.
  - At the edge: MIE<=MPIE, MPIE<=1.
- Simultaneous-event precedence: exception > interrupt > mret > CSR write.
- Counters:
  - mcycle increments every cycle, including while stalled.
  - minstret increments when retire_i=1.
  - A CSR write to a counter half in the same cycle wins over the increment.
  - Carry from the low word into the high word is exact (64-bit).

Optional Feature:
CSR_COUNTERS_EN
- Defined: mcycle/minstret and the read-only aliases (cycle/instret) are implemented as above.
- Undefined: no counter flops. Those addresses remain legal, read 0, and writes are discarded. illegal_csr_o behaviour is unchanged.

Test Plan:
- Reset, then csrrw 0x340 with wdata=0xDEADBEEF; then csrrs 0x340 with wdata=0 -> second read returns 0xDEADBEEF; mscratch is unchanged.
- mtvec=0x100; ecall at pc=0x80 (cause 11) -> PC_csr_o=1, trap_pc_o=0x100; next cycle mepc=0x80, mcause=11, MIE=0, MPIE=old MIE.
- After the trap, mret -> trap_pc_o=0x80; MIE restored from MPIE; MPIE=1.
- mtvec=0x201 (vectored), MIE=1, mie=0x880, ext_irq_i and timer_irq_i both high -> mcause=0x8000000B, trap_pc_o=0x22C.
- csrrw to 0xC00 -> illegal_csr_o=1, mcause=2, no write. csrrw to 0x7C0 -> same response.
- Stall high for 3 cycles with an ecall presented -> no mepc/mcause change until stall_i falls; mcycle still advances by 3 (with CSR_COUNTERS_EN).

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap responder: CSR read-modify-write, trap entry, mret and interrupt take.
// Latency: read data and redirect are combinational; all state updates land on the next clk_i edge.
// Backpressure: stall_i (or valid_i low) blocks every commit except the free-running counters; optional CSR_COUNTERS_EN adds mcycle/minstret.
module csr_unit #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        is_csr_i,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        is_trap_i,
    input  logic [3:0]  cause_trap_i,
    input  logic        is_mret_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] tval_i,
    input  logic        retire_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    output logic [31:0] csr_rdata_o,
    output logic        PC_csr_o,
    output logic [31:0] trap_pc_o,
    output logic        illegal_csr_o
);
    logic        commit, csr_acc, wr_intent, addr_known, addr_ro;
    logic        exc_take, irq_take, mret_take, csr_we;
    logic [31:0] old_val, new_val, mip_val, pend, tvec_base;
    logic [3:0]  irq_code;
    logic [63:0] cyc_v, ins_v;

    logic        st_mie, st_mpie, msip;
    logic [31:0] mie_r, mtvec, mscratch, mcause, mtval;
    logic [31:2] mepc;

    // pc_i[1:0] never reaches mepc (word-aligned)
    logic unused_ok;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret, cyc_inc, ins_inc;
    assign cyc_inc   = mcycle + 64'd1;
    assign ins_inc   = minstret + {63'd0, retire_i};
    assign cyc_v     = mcycle;
    assign ins_v     = minstret;
    assign unused_ok = &{1'b0, pc_i[1:0]};
`else
    assign cyc_v     = 64'd0;
    assign ins_v     = 64'd0;
    assign unused_ok = &{1'b0, pc_i[1:0], retire_i};
`endif

    assign commit    = valid_i & ~stall_i;
    assign csr_acc   = is_csr_i & ~is_mret_i & (csr_op_i != 2'b00);
    // set/clear with a zero mask is a pure read and never counts as a write
    assign wr_intent = (csr_op_i == 2'b01) | (csr_wdata_i != 32'd0);
    assign addr_ro   = (csr_addr_i[11:8] == 4'hC) | (csr_addr_i == 12'hF14);
    assign mip_val   = {20'd0, ext_irq_i, 3'd0, timer_irq_i, 3'd0, msip, 3'd0};
    assign pend      = mie_r & mip_val;
    assign tvec_base = {mtvec[31:2], 2'b00};

    // Read mux: returns the pre-write value and flags unknown addresses
    always_comb begin
        old_val    = 32'd0;
        addr_known = 1'b1;
        case (csr_addr_i)
            12'h300:          old_val = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
            12'h304:          old_val = mie_r;
            12'h305:          old_val = mtvec;
            12'h340:          old_val = mscratch;
            12'h341:          old_val = {mepc, 2'b00};
            12'h342:          old_val = mcause;
            12'h343:          old_val = mtval;
            12'h344:          old_val = mip_val;
            12'hB00, 12'hC00: old_val = cyc_v[31:0];
            12'hB80, 12'hC80: old_val = cyc_v[63:32];
            12'hB02, 12'hC02: old_val = ins_v[31:0];
            12'hB82, 12'hC82: old_val = ins_v[63:32];
            12'hF14:          old_val = HART_ID;
            default:          addr_known = 1'b0;
        endcase
    end

    // Read-modify-write value for the three CSR operations
    always_comb begin
        case (csr_op_i)
            2'b01:   new_val = csr_wdata_i;
            2'b10:   new_val = old_val | csr_wdata_i;
            2'b11:   new_val = old_val & ~csr_wdata_i;
            default: new_val = old_val;
        endcase
    end

    assign csr_rdata_o   = old_val;
    assign illegal_csr_o = csr_acc & (~addr_known | (addr_ro & wr_intent));

    // Event arbitration: exception > interrupt > mret > CSR write
    assign exc_take  = commit & (is_trap_i | illegal_csr_o);
    assign irq_take  = commit & st_mie & (|pend) & ~exc_take;
    assign mret_take = commit & is_mret_i & ~is_trap_i;
    assign csr_we    = commit & csr_acc & wr_intent & ~illegal_csr_o & ~exc_take & ~irq_take;
    assign irq_code  = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
    assign PC_csr_o  = ~rst_i & (exc_take | irq_take | mret_take);

    // Redirect target: trap base, vectored interrupt slot, or saved mepc
    always_comb begin
        trap_pc_o = tvec_base;
        if (exc_take)
            trap_pc_o = tvec_base;
        else if (irq_take)
            trap_pc_o = mtvec[0] ? tvec_base + {26'd0, irq_code, 2'b00} : tvec_base;
        else if (mret_take)
            trap_pc_o = {mepc, 2'b00};
    end

    // Architectural CSR state: trap/mret bookkeeping and software writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            msip     <= 1'b0;
            mie_r    <= 32'd0;
            mtvec    <= RESET_MTVEC & ~32'h2;
            mscratch <= 32'd0;
            mepc     <= 30'd0;
            mcause   <= 32'd0;
            mtval    <= 32'd0;
        end else if (exc_take) begin
            mepc    <= pc_i[31:2];
            mcause  <= {28'd0, is_trap_i ? cause_trap_i : 4'd2};
            mtval   <= is_trap_i ? tval_i : 32'd0;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (irq_take) begin
            mepc    <= pc_i[31:2];
            mcause  <= {1'b1, 27'd0, irq_code};
            mtval   <= 32'd0;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (mret_take) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr_i)
                12'h300: begin
                    st_mie  <= new_val[3];
                    st_mpie <= new_val[7];
                end
                12'h304: mie_r    <= new_val & 32'h0000_0888;
                12'h305: mtvec    <= {new_val[31:2], 1'b0, new_val[0]};
                12'h340: mscratch <= new_val;
                12'h341: mepc     <= new_val[31:2];
                12'h342: mcause   <= new_val;
                12'h343: mtval    <= new_val;
                12'h344: msip     <= new_val[3];
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    // Free-running 64-bit counters; a same-cycle write to one half wins over the increment
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcycle   <= 64'd0;
            minstret <= 64'd0;
        end else begin
            mcycle   <= cyc_inc;
            minstret <= ins_inc;
            if (csr_we) begin
                case (csr_addr_i)
                    12'hB00: mcycle   <= {cyc_inc[63:32], new_val};
                    12'hB80: mcycle   <= {new_val, cyc_inc[31:0]};
                    12'hB02: minstret <= {ins_inc[63:32], new_val};
                    12'hB82: minstret <= {new_val, ins_inc[31:0]};
                    default: ;
                endcase
            end
        end
    end
`endif
endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed checks of the main trap/CSR scenarios, then randomized traffic.
// Every cycle's combinational outputs are compared with a reference model of the CSR file.
// Inputs change #1 after the rising edge; outputs are sampled mid-cycle.
`timescale 1ns/1ps
module tb_csr_unit;
`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, valid, stall, is_csr, is_trap, is_mret, retire, ext_irq, timer_irq;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata, pc, tval;
    logic [3:0]  cause;
    logic [31:0] rdata, trap_pc;
    logic        pc_csr, illegal;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_mie, m_mpie, m_msip;
    logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;

    logic [11:0] addr_tab [19] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                   12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                   12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h301};

    csr_unit dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall), .is_csr_i(is_csr),
        .csr_op_i(op), .csr_addr_i(addr), .csr_wdata_i(wdata), .is_trap_i(is_trap),
        .cause_trap_i(cause), .is_mret_i(is_mret), .pc_i(pc), .tval_i(tval), .retire_i(retire),
        .ext_irq_i(ext_irq), .timer_irq_i(timer_irq), .csr_rdata_o(rdata), .PC_csr_o(pc_csr),
        .trap_pc_o(trap_pc), .illegal_csr_o(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
            12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
            12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] mipv;
        mipv = (32'(ext_irq) << 11) | (32'(timer_irq) << 7) | (32'(m_msip) << 3);
        case (a)
            12'h300:          return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304:          return m_mie_reg;
            12'h305:          return m_mtvec;
            12'h340:          return m_mscratch;
            12'h341:          return m_mepc;
            12'h342:          return m_mcause;
            12'h343:          return m_mtval;
            12'h344:          return mipv;
            12'hB00, 12'hC00: return CNT_EN ? m_cyc[31:0]  : 32'd0;
            12'hB80, 12'hC80: return CNT_EN ? m_cyc[63:32] : 32'd0;
            12'hB02, 12'hC02: return CNT_EN ? m_ins[31:0]  : 32'd0;
            12'hB82, 12'hC82: return CNT_EN ? m_ins[63:32] : 32'd0;
            default:          return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_msip = 0;
        m_mie_reg = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    task automatic m_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h304: m_mie_reg  = v & 32'h888;
            12'h305: m_mtvec    = v & 32'hFFFF_FFFD;
            12'h340: m_mscratch = v;
            12'h341: m_mepc     = v & 32'hFFFF_FFFC;
            12'h342: m_mcause   = v;
            12'h343: m_mtval    = v;
            12'h344: m_msip     = v[3];
            12'hB00: m_cyc[31:0]  = v;
            12'hB80: m_cyc[63:32] = v;
            12'hB02: m_ins[31:0]  = v;
            12'hB82: m_ins[63:32] = v;
            default: ;
        endcase
    endtask

    // One clock: compare outputs against the model, then advance the model at the edge
    task automatic cycle();
        bit acc, wr, ro, ill, cmt, exc, irq, mret, redir;
        logic [31:0] mipv, pend, oldv, newv, exp_pc, base;
        logic [3:0] code;
        #4;
        acc  = is_csr && !is_mret && op != 2'b00;
        wr   = (op == 2'b01) || (wdata != 0);
        ro   = (addr >= 12'hC00 && addr <= 12'hCFF) || addr == 12'hF14;
        ill  = acc && (!is_legal(addr) || (ro && wr));
        cmt  = valid && !stall;
        exc  = cmt && (is_trap || ill);
        mipv = (32'(ext_irq) << 11) | (32'(timer_irq) << 7) | (32'(m_msip) << 3);
        pend = m_mie_reg & mipv;
        irq  = cmt && m_mie && pend != 0 && !exc;
        code = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
        mret = cmt && is_mret && !is_trap;
        redir = !rst && (exc || irq || mret);
        base = m_mtvec & 32'hFFFF_FFFC;
        if (exc)      exp_pc = base;
        else if (irq) exp_pc = base + (m_mtvec[0] ? 32'(code) * 4 : 32'd0);
        else          exp_pc = m_mepc;
        oldv = m_read(addr);
        check("illegal", 32'(illegal), 32'(ill));
        check("redirect", 32'(pc_csr), 32'(redir));
        if (acc)   check("rdata", rdata, oldv);
        if (redir) check("trap_pc", trap_pc, exp_pc);
        @(posedge clk);
        if (rst) m_reset();
        else begin
            m_cyc = m_cyc + 1;
            if (retire) m_ins = m_ins + 1;
            if (exc) begin
                m_mepc = pc & 32'hFFFF_FFFC;
                m_mcause = is_trap ? 32'(cause) : 32'd2;
                m_mtval = is_trap ? tval : 32'd0;
                m_mpie = m_mie; m_mie = 0;
            end else if (irq) begin
                m_mepc = pc & 32'hFFFF_FFFC;
                m_mcause = 32'h8000_0000 | 32'(code);
                m_mtval = 0;
                m_mpie = m_mie; m_mie = 0;
            end else if (mret) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (cmt && acc && wr && !ill) begin
                case (op)
                    2'b01:   newv = wdata;
                    2'b10:   newv = oldv | wdata;
                    default: newv = oldv & ~wdata;
                endcase
                m_write(addr, newv);
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; valid = 0; stall = 0; is_csr = 0; op = 0; addr = 0; wdata = 0;
        is_trap = 0; cause = 0; is_mret = 0; pc = 0; tval = 0; retire = 0;
        ext_irq = 0; timer_irq = 0;
    endtask

    task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [31:0] w);
        idle(); valid = 1; is_csr = 1; op = o; addr = a; wdata = w;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        csr(2'b10, a, 32'd0);
        #2 check(tag, rdata, exp);
        cycle();
    endtask

    initial begin
        int r;
        m_reset();
        idle(); rst = 1;
        repeat (2) cycle();
        // reset held with an ecall presented: no redirect
        idle(); rst = 1; valid = 1; is_trap = 1; cause = 11; pc = 32'h40;
        #2 check("rst_no_redirect", 32'(pc_csr), 32'd0);
        cycle();
        rd(12'h300, 32'h0000_1800, "rst_mstatus");
        rd(12'h305, 32'h0, "rst_mtvec");
        rd(12'h341, 32'h0, "rst_mepc");
        rd(12'h304, 32'h0, "rst_mie");
        rd(12'hF14, 32'h0, "mhartid");
        // mscratch read-modify-write
        csr(2'b01, 12'h340, 32'hDEAD_BEEF);
        #2 check("csrrw_old", rdata, 32'h0);
        cycle();
        rd(12'h340, 32'hDEAD_BEEF, "csrrs_read");
        rd(12'h340, 32'hDEAD_BEEF, "mscratch_kept");
        // ecall with MIE=1, then mret
        csr(2'b01, 12'h305, 32'h100); cycle();
        csr(2'b10, 12'h300, 32'h8);   cycle();
        idle(); valid = 1; is_trap = 1; cause = 11; pc = 32'h80;
        #2 check("ecall_redirect", 32'(pc_csr), 32'd1);
        check("ecall_target", trap_pc, 32'h100);
        cycle();
        rd(12'h341, 32'h80, "ecall_mepc");
        rd(12'h342, 32'd11, "ecall_mcause");
        rd(12'h300, 32'h1880, "ecall_mstatus");
        idle(); valid = 1; is_csr = 1; is_mret = 1;
        #2 check("mret_target", trap_pc, 32'h80);
        cycle();
        rd(12'h300, 32'h1888, "mret_mstatus");
        // vectored interrupt, external beats timer, CSR write suppressed
        csr(2'b01, 12'h305, 32'h201); cycle();
        csr(2'b01, 12'h304, 32'h880); cycle();
        csr(2'b01, 12'h340, 32'h55); pc = 32'h120; ext_irq = 1; timer_irq = 1;
        #2 check("irq_redirect", 32'(pc_csr), 32'd1);
        check("irq_target", trap_pc, 32'h22C);
        cycle();
        rd(12'h342, 32'h8000_000B, "irq_mcause");
        rd(12'h340, 32'hDEAD_BEEF, "irq_write_suppressed");
        rd(12'h341, 32'h120, "irq_mepc");
        rd(12'h300, 32'h1880, "irq_mstatus");
        // illegal accesses
        csr(2'b01, 12'h343, 32'h1234); cycle();
        csr(2'b01, 12'h342, 32'h0);    cycle();
        csr(2'b01, 12'hC00, 32'h5);
        #2 check("ill_ro_flag", 32'(illegal), 32'd1);
        check("ill_ro_target", trap_pc, 32'h200);
        cycle();
        rd(12'h342, 32'd2, "ill_ro_mcause");
        rd(12'h343, 32'd0, "ill_ro_mtval");
        csr(2'b01, 12'h342, 32'h0); cycle();
        csr(2'b01, 12'h7C0, 32'h5);
        #2 check("ill_unknown_flag", 32'(illegal), 32'd1);
        cycle();
        rd(12'h342, 32'd2, "ill_unknown_mcause");
        csr(2'b11, 12'hC00, 32'h0);
        #2 check("ro_pure_read", 32'(illegal), 32'd0);
        cycle();
        // counter carry across halves
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF); cycle();
        rd(12'hB80, CNT_EN ? m_cyc[63:32] : 32'd0, "mcycleh_pre_carry");
        rd(12'hB80, CNT_EN ? m_cyc[63:32] : 32'd0, "mcycleh_carry");
        // stalled ecall: nothing commits until stall falls
        rd(12'hB00, CNT_EN ? m_cyc[31:0] : 32'd0, "mcycle_pre_stall");
        idle(); valid = 1; stall = 1; is_trap = 1; cause = 11; pc = 32'h300; tval = 32'h77;
        for (int k = 0; k < 3; k++) begin
            #2 check("stall_no_redirect", 32'(pc_csr), 32'd0);
            cycle();
        end
        stall = 0;
        #2 check("stall_release_redirect", 32'(pc_csr), 32'd1);
        cycle();
        rd(12'h341, 32'h300, "stall_mepc");
        rd(12'h343, 32'h77, "stall_mtval");
        rd(12'hB00, CNT_EN ? m_cyc[31:0] : 32'd0, "mcycle_post_stall");
        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            idle();
            valid     = ($urandom_range(0, 9) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            retire    = 1'($urandom_range(0, 1));
            ext_irq   = ($urandom_range(0, 7) == 0);
            timer_irq = ($urandom_range(0, 7) == 0);
            pc        = $urandom;
            tval      = $urandom;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                is_trap = 1;
                case ($urandom_range(0, 2))
                    0:       cause = 4'd2;
                    1:       cause = 4'd3;
                    default: cause = 4'd11;
                endcase
            end else if (r < 14) begin
                is_csr = 1; is_mret = 1;
            end else if (r < 75) begin
                is_csr = 1;
                op     = 2'($urandom_range(0, 3));
                addr   = addr_tab[$urandom_range(0, 18)];
                wdata  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            end
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
